// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and the
// BOOT/RUN/HALT sequencer, with redirect, stall, flush and fetch-error handling.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic        fetch_in_range;
    logic        capture;

    // jump outranks branch_taken when both redirect in the same cycle
    assign redirect        = jump | branch_taken;
    assign redirect_target = jump ? jump_target : branch_target;
    assign pc_plus4        = pc_q + 32'd4;
    assign fetch_in_range  = ({2'b00, pc_q[31:2]} < MEM_LIMIT);
    // the fetched word is only consumed when nothing squashes or holds IF/ID
    assign capture         = ~stall & ~flush & ~redirect;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        err_d   = err_q;

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                instr_d = NOP;
                pc4_d   = '0;
                valid_d = 1'b0;
            end

            RUN: begin
                if (redirect) begin
                    pc_d    = {redirect_target[31:2], 2'b00};
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    if (redirect_target[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end
                end else if (stall) begin
                    if (flush) begin
                        instr_d = NOP;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (flush) begin
                    pc_d    = pc_plus4;
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else if (!fetch_in_range) begin
                    pc_d    = pc_plus4;
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                end else if (imem_instr == HALT_WORD) begin
                    state_d = HALT;
                    instr_d = NOP;
                    pc4_d   = '0;
                    valid_d = 1'b0;
                end else begin
                    pc_d    = pc_plus4;
                    instr_d = imem_instr;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end

            HALT: begin
                instr_d = NOP;
                pc4_d   = '0;
                valid_d = 1'b0;
            end

            default: begin
                state_d = BOOT;
                pc_d    = RESET_PC;
                instr_d = NOP;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign imem_addr  = pc_q;
    assign ifid_instr = instr_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_valid = valid_q;
    assign halted     = (state_q == HALT);
    assign fetch_err  = err_q;

    // capture is informational for the fetch decision tree above
    logic unused_capture;
    assign unused_capture = capture;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random stimulus,
// all compared against a rule-level reference model of the fetch stage.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int unsigned MEM_WORDS = 256;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] OOR_WORD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset, stall, flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] ifid_instr, ifid_pc4;
    logic        ifid_valid, halted, fetch_err;

    logic [31:0] mem [MEM_WORDS];

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted, m_err, m_boot;

    pc_fetch_unit #(
        .RESET_PC (RESET_PC),
        .MEM_WORDS(MEM_WORDS),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        if ((imem_addr >> 2) < MEM_WORDS) imem_instr = mem[imem_addr[9:2]];
        else                              imem_instr = OOR_WORD;
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bubble_model();
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // one clock: drive inputs, advance the model by the fetch rules, compare
    task automatic step(input bit rst, input bit st, input bit fl,
                        input bit br, input logic [31:0] bt,
                        input bit jp, input logic [31:0] jt);
        logic [31:0] word, tgt;
        reset = rst; stall = st; flush = fl;
        branch_taken = br; branch_target = bt;
        jump = jp; jump_target = jt;

        word = ((m_pc >> 2) < MEM_WORDS) ? mem[m_pc >> 2] : OOR_WORD;
        if (rst) begin
            m_pc = RESET_PC; bubble_model();
            m_halted = 0; m_err = 0; m_boot = 1;
        end else if (m_boot) begin
            m_boot = 0; bubble_model();
        end else if (m_halted) begin
            bubble_model();
        end else if (jp || br) begin
            tgt = jp ? jt : bt;
            if (tgt % 4 != 0) m_err = 1;
            m_pc = tgt - (tgt % 4);
            bubble_model();
        end else if (st) begin
            if (fl) bubble_model();
        end else if (fl) begin
            bubble_model();
            m_pc = m_pc + 4;
        end else if ((m_pc >> 2) >= MEM_WORDS) begin
            m_err = 1; bubble_model();
            m_pc = m_pc + 4;
        end else if (word == HALT_WORD) begin
            m_halted = 1; bubble_model();
        end else begin
            m_instr = word; m_pc4 = m_pc + 4; m_valid = 1;
            m_pc = m_pc + 4;
        end

        @(posedge clk);
        #1;
        check32("imem_addr",  imem_addr,  m_pc);
        check32("ifid_instr", ifid_instr, m_instr);
        check32("ifid_pc4",   ifid_pc4,   m_pc4);
        check32("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        check32("halted",     {31'b0, halted},     {31'b0, m_halted});
        check32("fetch_err",  {31'b0, fetch_err},  {31'b0, m_err});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] a, b, c, d, r, t;
        bit rst, st, fl, br, jp;

        a = 32'h1111_0001; b = 32'h2222_0002; c = 32'h3333_0003; d = 32'h4444_0004;
        for (int unsigned i = 0; i < MEM_WORDS; i++) begin
            r = $urandom;
            if (r == HALT_WORD) r = 32'h0000_1234;
            mem[i] = r;
        end
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 0; m_halted = 0; m_err = 0; m_boot = 1;

        // reset and sequential run
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check32("rst_addr", imem_addr, 32'h0);
        check32("rst_valid", {31'b0, ifid_valid}, 32'h0);
        idle();
        check32("boot_addr", imem_addr, 32'h0);
        check32("boot_valid", {31'b0, ifid_valid}, 32'h0);
        idle();
        check32("seq_addr4", imem_addr, 32'h4);
        check32("seq_instrA", ifid_instr, a);
        check32("seq_pc4_4", ifid_pc4, 32'h4);
        idle();
        check32("seq_addr8", imem_addr, 32'h8);
        check32("seq_instrB", ifid_instr, b);

        // stall two cycles at PC=8
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        check32("stall_addr", imem_addr, 32'h8);
        check32("stall_instr", ifid_instr, b);
        check32("stall_pc4", ifid_pc4, 32'h8);
        idle();
        check32("resume_instrC", ifid_instr, c);
        check32("resume_addr", imem_addr, 32'hC);

        // branch with stall at PC=12
        step(0, 1, 0, 1, 32'h40, 0, 0);
        check32("brstall_addr", imem_addr, 32'h40);
        check32("brstall_valid", {31'b0, ifid_valid}, 32'h0);
        check32("brstall_instr", ifid_instr, 32'h0);

        // flush alone, flush over stall
        idle();
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        check32("flush_valid", {31'b0, ifid_valid}, 32'h0);

        // jump beats branch; misaligned jump
        step(0, 0, 0, 1, 32'h40, 1, 32'h80);
        check32("jmpbr_addr", imem_addr, 32'h80);
        step(0, 0, 0, 0, 0, 1, 32'h82);
        check32("misal_addr", imem_addr, 32'h80);
        check32("misal_err", {31'b0, fetch_err}, 32'h1);
        idle();
        check32("err_sticky", {31'b0, fetch_err}, 32'h1);

        // out of range and wrap
        step(0, 0, 0, 0, 0, 1, 32'h400);
        idle();
        check32("oor_valid", {31'b0, ifid_valid}, 32'h0);
        check32("oor_addr", imem_addr, 32'h404);
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        idle();
        check32("wrap_addr", imem_addr, 32'h0);

        // halt on sentinel at 0x10
        mem[4] = HALT_WORD;
        step(1, 0, 0, 0, 0, 0, 0);
        check32("rst_err_clear", {31'b0, fetch_err}, 32'h0);
        for (int i = 0; i < 6; i++) idle();
        check32("halt_flag", {31'b0, halted}, 32'h1);
        check32("halt_addr", imem_addr, 32'h10);
        step(0, 0, 0, 0, 0, 1, 32'h20);
        step(0, 1, 1, 1, 32'h30, 1, 32'h20);
        check32("halt_jmp_ignored", imem_addr, 32'h10);
        step(1, 0, 0, 0, 0, 0, 0);
        check32("halt_reset", {31'b0, halted}, 32'h0);
        check32("halt_reset_addr", imem_addr, RESET_PC);

        // redirect beats sentinel
        for (int i = 0; i < 5; i++) idle();
        step(0, 0, 0, 1, 32'h8, 0, 0);
        check32("redir_vs_halt", {31'b0, halted}, 32'h0);
        mem[4] = 32'h5555_0005;

        // randomized phase
        for (int unsigned i = 0; i < MEM_WORDS; i++) begin
            if ($urandom_range(0, 19) == 0) mem[i] = HALT_WORD;
        end
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 49) == 0) || (m_halted && $urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            br  = ($urandom_range(0, 9) == 0);
            jp  = ($urandom_range(0, 14) == 0);
            t = {22'b0, 8'($urandom), 2'b00};
            case ($urandom_range(0, 19))
                0:       t[1:0] = 2'($urandom_range(1, 3));
                1:       t = $urandom;
                default: ;
            endcase
            r = {22'b0, 8'($urandom), 2'b00};
            step(rst, st, fl, br, r, jp, t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
